serial_deserializer: RTL and testbench

Serial-in, parallel-out receiver that rebuilds SIZE-bit words from a bit stream sent MSB-first, one bit per strobe. It pairs with the parallel-load, shift-left transmit register: the receiver sits at the far end of the serial link. Completed words go to a holding register with a valid/ready handshake toward the consumer. A sticky overrun flag records any word lost because the consumer did not take the previous one.

---
 rtl/serial_deserializer.sv | 96 +++++++++
 tb/tb_serial_deserializer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_deserializer.sv
// serial_deserializer
//   Serial-in, parallel-out receiver. Rebuilds SIZE-bit words sent MSB-first,
//   one bit per shEN strobe, and hands completed words to a consumer through
//   a holding register with a valid/ready handshake. A sticky overrun flag
//   records any completed word dropped because the previous one was not taken.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset, highest priority
//   serialIN     serial data bit, MSB of each word first
//   shEN         bit strobe; serialIN is sampled on edges where shEN=1
//   clr          synchronous frame abort; drops the partial word, clears overrun
//   outReady     consumer accepts the held word
//   parallelOUT  last completed word
//   outValid     parallelOUT holds an unconsumed word
//   busy         a partial word is in progress
//   overrun      sticky: a completed word was dropped
module serial_deserializer #(
    parameter int SIZE = 9,
    parameter int CNTW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            serialIN,
    input  logic            shEN,
    input  logic            clr,
    input  logic            outReady,
    output logic [SIZE-1:0] parallelOUT,
    output logic            outValid,
    output logic            busy,
    output logic            overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam logic [CNTW-1:0] LAST_BIT = CNTW'(SIZE - 1);

    state_t          state;
    logic [SIZE-1:0] sr;
    logic [CNTW-1:0] cnt;
    logic [SIZE-1:0] next_word;

    // Word as it stands after this edge's sample; on the last bit this is
    // the completed word.
    assign next_word = {sr[SIZE-2:0], serialIN};

    // busy is a decode of the registered state bit, so it is glitch-free and
    // changes only on a clock edge.
    assign busy = (state == RECV);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sr          <= '0;
            cnt         <= '0;
            parallelOUT <= '0;
            outValid    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let a later assignment in this
            // block override an earlier one for the same edge; the consume
            // below is the default and a same-edge completion re-asserts it.
            if (outValid && outReady) begin
                outValid <= 1'b0;
            end

            if (clr) begin
                // Abort wins over a same-edge strobe; the sampled bit is lost.
                state   <= IDLE;
                sr      <= '0;
                cnt     <= '0;
                overrun <= 1'b0;
            end else if (shEN) begin
                sr <= next_word;
                if (cnt == LAST_BIT) begin
                    cnt   <= '0;
                    state <= IDLE;
                    if (!outValid || outReady) begin
                        parallelOUT <= next_word;
                        outValid    <= 1'b1;
                    end else begin
                        // Holding register still owned by the consumer.
                        overrun <= 1'b1;
                    end
                end else begin
                    cnt   <= cnt + 1'b1;
                    state <= RECV;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_deserializer.sv
// tb_serial_deserializer
//   Self-checking bench for serial_deserializer (SIZE=9). A small behavioural
//   model decides, bit by bit, whether a word completes and is accepted; the
//   expected word is pushed to a scoreboard queue when its last bit is driven
//   and popped for comparison once the DUT has taken the edge.
module tb_serial_deserializer;

    localparam int SIZE = 9;
    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            serial_in;
    logic            sh_en;
    logic            clr;
    logic            out_ready;
    logic [SIZE-1:0] parallel_out;
    logic            out_valid;
    logic            busy;
    logic            overrun;

    serial_deserializer #(.SIZE(SIZE), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst        (rst),
        .serialIN   (serial_in),
        .shEN       (sh_en),
        .clr        (clr),
        .outReady   (out_ready),
        .parallelOUT(parallel_out),
        .outValid   (out_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int check_count = 0;
    int error_count = 0;

    // Reference state
    logic [SIZE-1:0] exp_q[$];
    logic [SIZE-1:0] m_bits;
    int              m_cnt;
    logic            m_valid;
    logic            m_ovr;
    logic [SIZE-1:0] m_par;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, update the model, take the edge, compare at #1.
    task automatic tick(input logic sin, input logic sh, input logic cl,
                        input logic rdy, input logic rs, input string tag);
        logic pushed;
        pushed    = 1'b0;
        serial_in = sin;
        sh_en     = sh;
        clr       = cl;
        out_ready = rdy;
        rst       = rs;

        if (rs) begin
            m_bits  = '0;
            m_cnt   = 0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_par   = '0;
            exp_q.delete();
        end else begin
            logic consume;
            consume = m_valid && rdy;
            if (consume) m_valid = 1'b0;
            if (cl) begin
                m_bits = '0;
                m_cnt  = 0;
                m_ovr  = 1'b0;
            end else if (sh) begin
                m_bits = {m_bits[SIZE-2:0], sin};
                if (m_cnt == SIZE - 1) begin
                    m_cnt = 0;
                    if (consume || !m_valid) begin
                        exp_q.push_back(m_bits);
                        m_valid = 1'b1;
                        pushed  = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else begin
                    m_cnt++;
                end
            end
        end

        @(posedge clk);
        #1;
        if (pushed) m_par = exp_q.pop_front();
        check({tag, ".par"},   32'(parallel_out), 32'(m_par));
        check({tag, ".valid"}, 32'(out_valid),    32'(m_valid));
        check({tag, ".busy"},  32'(busy),         32'(m_cnt != 0));
        check({tag, ".ovr"},   32'(overrun),      32'(m_ovr));
    endtask

    // Send one word MSB-first with `gap` idle cycles between strobes;
    // rdy_rest drives outReady during the early bits, rdy_last on the final one.
    task automatic send_word(input logic [SIZE-1:0] w, input int gap,
                             input logic rdy_rest, input logic rdy_last,
                             input string tag);
        for (int i = SIZE - 1; i >= 0; i--) begin
            tick(w[i], 1'b1, 1'b0, (i == 0) ? rdy_last : rdy_rest, 1'b0, tag);
            if (i != 0) begin
                for (int g = 0; g < gap; g++) tick(1'b0, 1'b0, 1'b0, rdy_rest, 1'b0, tag);
            end
        end
    endtask

    task automatic idle(input logic rdy, input string tag);
        tick(1'b0, 1'b0, 1'b0, rdy, 1'b0, tag);
    endtask

    initial begin
        serial_in = 1'b0;
        sh_en     = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;

        // Reset state
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "reset");
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "reset2");

        // Contiguous 9'h165 with no consumer
        send_word(9'h165, 0, 1'b0, 1'b0, "w165");
        check("w165.abs_par", 32'(parallel_out), 32'h165);
        idle(1'b0, "hold");

        // Consume, then the same word with a strobe every 3rd cycle
        idle(1'b1, "consume1");
        check("consume1.abs_valid", 32'(out_valid), 32'h0);
        send_word(9'h165, 2, 1'b0, 1'b0, "gap165");
        check("gap165.abs_par", 32'(parallel_out), 32'h165);

        // Dropped word while 9'h165 is held, then clr clears overrun only
        send_word(9'h0AA, 0, 1'b0, 1'b0, "drop");
        check("drop.abs_par", 32'(parallel_out), 32'h165);
        check("drop.abs_ovr", 32'(overrun), 32'h1);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "clr_ovr");

        // Consume on the exact completion edge of 9'h1FF
        send_word(9'h1FF, 0, 1'b0, 1'b1, "same_edge");
        check("same_edge.abs_par", 32'(parallel_out), 32'h1FF);
        idle(1'b1, "consume2");

        // Abort after 4 bits with a simultaneous strobe, then 9'h101
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "partial");
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "abort");
        check("abort.abs_busy", 32'(busy), 32'h0);
        send_word(9'h101, 0, 1'b0, 1'b0, "w101");
        check("w101.abs_par", 32'(parallel_out), 32'h101);

        // Reset mid-frame with a word held
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "pre_rst");
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "mid_rst");
        check("mid_rst.abs_par", 32'(parallel_out), 32'h0);
        send_word(9'h0F3, 0, 1'b0, 1'b0, "after_rst");

        // Back-to-back words, consumer always ready
        send_word(9'h12C, 0, 1'b1, 1'b1, "b2b_a");
        send_word(9'h0D5, 0, 1'b1, 1'b1, "b2b_b");
        send_word(9'h000, 0, 1'b1, 1'b1, "b2b_c");

        // Random words, gaps and readiness
        for (int n = 0; n < 12; n++) begin
            send_word(9'($urandom), int'($urandom_range(0, 2)),
                      1'($urandom), 1'($urandom), "rand");
            if ($urandom_range(0, 3) == 0) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "rand_clr");
        end
        idle(1'b1, "drain");

        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
